// File: rtl/avr_cmd_pkg.sv
// Shared definitions for the AVR control-code bus: command codes, request op
// encodings and the sequencer state type.
package avr_cmd_pkg;

  localparam logic [6:0] CMD_IDLE         = 7'h01;
  localparam logic [6:0] CMD_RESET_LO     = 7'h02;
  localparam logic [6:0] CMD_RESET_HI     = 7'h03;
  localparam logic [6:0] CMD_SREG_EN_LO   = 7'h04;
  localparam logic [6:0] CMD_SREG_EN_HI   = 7'h05;
  localparam logic [6:0] CMD_SI_LO        = 7'h06;
  localparam logic [6:0] CMD_SI_HI        = 7'h07;
  localparam logic [6:0] CMD_OE_LO        = 7'h08;
  localparam logic [6:0] CMD_OE_HI        = 7'h09;
  localparam logic [6:0] CMD_WE_LO        = 7'h0A;
  localparam logic [6:0] CMD_WE_HI        = 7'h0C;
  localparam logic [6:0] CMD_COUNTER_LO   = 7'h0D;
  localparam logic [6:0] CMD_COUNTER_HI   = 7'h0E;
  localparam logic [6:0] CMD_SNES_MODE_LO = 7'h0F;
  localparam logic [6:0] CMD_SNES_MODE_HI = 7'h10;

  localparam logic [1:0] OP_RESET     = 2'd0;
  localparam logic [1:0] OP_LOAD_ADDR = 2'd1;
  localparam logic [1:0] OP_WRITE     = 2'd2;
  localparam logic [1:0] OP_READ      = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/avr_cmd_slot_timer.sv
// Hold counter for one command slot; loaded with (hold cycles - 1) as a code is
// issued, reports slot_done in the last cycle the code is held.
module avr_cmd_slot_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_hold_m1,
  output logic             o_slot_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_hold_m1;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_slot_done = (r_cnt == '0);

endmodule

// File: rtl/avr_command_sequencer.sv
// Expands RESET / LOAD_ADDR / WRITE / READ requests into timed command-code
// slots on avr_ctrl, each code held then separated by one IDLE cycle.
module avr_command_sequencer
  import avr_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned STEP_CYCLES  = 2,
  parameter int unsigned RESET_CYCLES = 8
) (
  input  logic              avr_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_inc,
  output logic [6:0]        avr_ctrl,
  output logic              rd_sample,
  output logic              done,
  output logic              busy
);

  localparam int unsigned HOLD_MAX = (RESET_CYCLES > STEP_CYCLES) ? RESET_CYCLES : STEP_CYCLES;
  localparam int unsigned CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int unsigned BIT_W    = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam logic [CNT_W-1:0] STEP_M1  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_M1 = CNT_W'(RESET_CYCLES - 1);

  // Step numbering per op; LOAD_ADDR loops steps 1..3 once per address bit.
  function automatic logic [6:0] code_of(input logic [1:0] op, input logic [2:0] step,
                                         input logic si);
    logic [6:0] c;
    c = CMD_IDLE;
    case (op)
      OP_RESET: c = (step == 3'd0) ? CMD_RESET_HI : CMD_RESET_LO;
      OP_LOAD_ADDR:
        case (step)
          3'd0:    c = CMD_SREG_EN_LO;
          3'd1:    c = si ? CMD_SI_HI : CMD_SI_LO;
          3'd2:    c = CMD_COUNTER_LO;
          3'd3:    c = CMD_COUNTER_HI;
          default: c = CMD_SREG_EN_HI;
        endcase
      OP_WRITE:
        case (step)
          3'd0:    c = CMD_WE_LO;
          3'd1:    c = CMD_WE_HI;
          3'd2:    c = CMD_COUNTER_LO;
          default: c = CMD_COUNTER_HI;
        endcase
      default:
        case (step)
          3'd0:    c = CMD_OE_LO;
          3'd1:    c = CMD_OE_HI;
          3'd2:    c = CMD_COUNTER_LO;
          default: c = CMD_COUNTER_HI;
        endcase
    endcase
    return c;
  endfunction

  seq_state_e        r_state, w_state_next;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inc;
  logic [2:0]        r_step, w_step_next;
  logic [BIT_W-1:0]  r_bit, w_bit_next;
  logic [6:0]        r_ctrl, w_ctrl_next;
  logic              w_accept, w_advance, w_last, w_slot_done;
  logic [CNT_W-1:0]  w_hold_m1;

  always_ff @(posedge avr_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_last = 1'b0;
    case (r_op)
      OP_RESET:     w_last = (r_step == 3'd1);
      OP_LOAD_ADDR: w_last = (r_step == 3'd4);
      default:      w_last = (r_step == (r_inc ? 3'd3 : 3'd1));
    endcase
  end

  always_comb begin
    w_step_next = r_step + 3'd1;
    w_bit_next  = r_bit;
    if (r_op == OP_LOAD_ADDR && r_step == 3'd3) begin
      if (r_bit == '0) begin
        w_step_next = 3'd4;
      end else begin
        w_step_next = 3'd1;
        w_bit_next  = r_bit - BIT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    w_ctrl_next  = r_ctrl;
    done         = 1'b0;
    rd_sample    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_ctrl_next  = code_of(req_op, 3'd0, 1'b0);
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        rd_sample = w_slot_done && (r_op == OP_READ) && (r_step == 3'd0);
        if (w_slot_done) begin
          w_ctrl_next  = CMD_IDLE;
          w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (w_last) begin
          done         = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_advance    = 1'b1;
          w_ctrl_next  = code_of(r_op, w_step_next, r_addr[w_bit_next]);
          w_state_next = S_HOLD;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge avr_clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= CMD_IDLE;
      r_step <= '0;
      r_bit  <= '0;
      r_op   <= '0;
      r_inc  <= 1'b0;
    end else begin
      r_ctrl <= w_ctrl_next;
      if (w_accept) begin
        r_step <= '0;
        r_bit  <= BIT_W'(ADDR_W - 1);
        r_op   <= req_op;
        r_inc  <= req_inc;
      end else if (w_advance) begin
        r_step <= w_step_next;
        r_bit  <= w_bit_next;
      end
    end
  end

  always_ff @(posedge avr_clk) begin
    if (w_accept) r_addr <= req_addr;
  end

  assign w_hold_m1 = (w_ctrl_next == CMD_RESET_HI) ? RESET_M1 : STEP_M1;

  avr_cmd_slot_timer #(.CNT_W(CNT_W)) u_slot_timer (
    .i_clk       (avr_clk),
    .i_rst       (reset),
    .i_load      (w_accept | w_advance),
    .i_hold_m1   (w_hold_m1),
    .o_slot_done (w_slot_done)
  );

  assign avr_ctrl  = r_ctrl;
  assign req_ready = (r_state == S_IDLE);
  assign busy      = ~req_ready;

endmodule
